des_key_sched_ctrl: RTL

//  Iterative DES key-schedule sequencer. Accepts one 64-bit key plus an enc/dec mode,

---
 rtl/des_pkg.sv | 23 ++
 rtl/des_key_sched_ctrl_if.sv | 28 ++
 rtl/des_cd_rotate.sv | 23 ++
 rtl/pc1.sv | 22 ++
 rtl/pc2.sv | 22 ++
 rtl/des_key_sched_ctrl.sv | 111 +++++++++++
 6 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: widths, round count, per-round shift table and
// the sequencer state encoding.
package des_pkg;
   localparam int unsigned ROUNDS = 16;
   localparam int unsigned KEY_W  = 64;
   localparam int unsigned CD_W   = 56;
   localparam int unsigned HALF_W = 28;
   localparam int unsigned SK_W   = 48;
   localparam int unsigned IDX_W  = 5;

   // Bit r set: round r rotates C/D by two places; clear: by one (rounds 1, 2, 9, 16).
   localparam logic [ROUNDS:1] SHIFT_TABLE = 16'h7EFC;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic shift_two(input logic [IDX_W-1:0] r);
      return |({SHIFT_TABLE, 1'b0} & ((ROUNDS + 1)'(1) << r));
   endfunction
endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// Key request and subkey stream between the key-schedule sequencer (slave) and the
// round datapath that feeds it keys and consumes subkeys (master).
interface des_key_sched_ctrl_if;
   import des_pkg::*;

   logic [KEY_W-1:0] i_key;
   logic             i_decrypt;
   logic             i_key_valid;
   logic             o_key_ready;
   logic             o_key_err;
   logic [SK_W-1:0]  o_sk;
   logic [IDX_W-1:0] o_sk_idx;
   logic             o_sk_valid;
   logic             i_sk_ready;
   logic             o_sk_last;
   logic             o_done;
   logic             i_abort;

   modport master (
      output i_key, i_decrypt, i_key_valid, i_sk_ready, i_abort,
      input  o_key_ready, o_key_err, o_sk, o_sk_idx, o_sk_valid, o_sk_last, o_done
   );

   modport slave (
      input  i_key, i_decrypt, i_key_valid, i_sk_ready, i_abort,
      output o_key_ready, o_key_err, o_sk, o_sk_idx, o_sk_valid, o_sk_last, o_done
   );
endinterface

// File: rtl/des_cd_rotate.sv
// Rotates the C and D halves independently by one or two places, left (encrypt) or
// right (decrypt). Purely combinational.
module des_cd_rotate
   import des_pkg::*;
(
   input  logic [CD_W-1:0] i_cd,
   input  logic            i_two,
   input  logic            i_right,
   output logic [CD_W-1:0] o_cd
);
   function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] x,
                                             input logic two, input logic right);
      case ({right, two})
         2'b00:   return {x[HALF_W-2:0], x[HALF_W-1]};
         2'b01:   return {x[HALF_W-3:0], x[HALF_W-1 -: 2]};
         2'b10:   return {x[0], x[HALF_W-1:1]};
         default: return {x[1:0], x[HALF_W-1:2]};
      endcase
   endfunction

   assign o_cd = {rot(i_cd[CD_W-1:HALF_W], i_two, i_right),
                  rot(i_cd[HALF_W-1:0],    i_two, i_right)};
endmodule

// File: rtl/pc1.sv
// Permuted Choice 1: 64-bit key (DES bit 1 at the MSB) to the 56-bit {C0,D0}; parity bits dropped.
module pc1
   import des_pkg::*;
(
   input  logic [KEY_W-1:0] i_key,
   output logic [CD_W-1:0]  o_cd
);
   localparam int unsigned TBL [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   for (genvar i = 0; i < CD_W; i++) begin : g_bit
      assign o_cd[CD_W-1-i] = i_key[KEY_W-TBL[i]];
   end
endmodule

// File: rtl/pc2.sv
// Permuted Choice 2: 56-bit {C,D} to the 48-bit round subkey (subkey bit 1 at the MSB).
module pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0] i_cd,
   output logic [SK_W-1:0] o_sk
);
   localparam int unsigned TBL [SK_W] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   for (genvar i = 0; i < SK_W; i++) begin : g_bit
      assign o_sk[SK_W-1-i] = i_cd[CD_W-TBL[i]];
   end
endmodule

// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key-schedule sequencer: takes one key plus mode and streams the 16 round
// subkeys, one per handshake, in K1..K16 (encrypt) or K16..K1 (decrypt) order.
module des_key_sched_ctrl
   import des_pkg::*;
#(
   parameter bit CHK_PARITY = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   des_key_sched_ctrl_if.slave  bus
);
   state_e            state_q, state_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              mode_q, mode_d;
   logic              err_q, err_d;

   logic [CD_W-1:0]   pc1_cd, rot_in, rot_cd;
   logic              rot_two, rot_right;
   logic [SK_W-1:0]   sk;
   logic [7:0]        byte_odd;
   logic              parity_bad, accept, last;

   pc1 u_pc1 (.i_key(bus.i_key), .o_cd(pc1_cd));
   pc2 u_pc2 (.i_cd(cd_q), .o_sk(sk));

   // In IDLE the rotator pre-applies round 1's shift to the fresh PC1 output.
   assign rot_in    = (state_q == IDLE) ? pc1_cd : cd_q;
   assign rot_right = (state_q == RUN) && mode_q;
   assign rot_two   = (state_q == RUN) &&
                      (mode_q ? shift_two(idx_q) : shift_two(idx_q + IDX_W'(1)));

   des_cd_rotate u_rot (.i_cd(rot_in), .i_two(rot_two), .i_right(rot_right), .o_cd(rot_cd));

   for (genvar b = 0; b < 8; b++) begin : g_par
      assign byte_odd[b] = ^bus.i_key[8*b +: 8];
   end
   assign parity_bad = ~&byte_odd;

   assign accept = bus.i_key_valid && (state_q == IDLE);
   assign last   = mode_q ? (idx_q == IDX_W'(1)) : (idx_q == IDX_W'(ROUNDS));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cd_q    <= '0;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (CHK_PARITY && parity_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = RUN;
                  mode_d  = bus.i_decrypt;
                  // Decrypt starts at C16/D16, which equals C0/D0 after 28 cumulative shifts.
                  cd_d    = bus.i_decrypt ? pc1_cd : rot_cd;
                  idx_d   = bus.i_decrypt ? IDX_W'(ROUNDS) : IDX_W'(1);
               end
            end
         end
         RUN: begin
            if (bus.i_sk_ready) begin
               if (last) begin
                  state_d = DONE;
               end else begin
                  cd_d  = rot_cd;
                  idx_d = mode_q ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
         end
         default: state_d = IDLE;
      endcase
      if (bus.i_abort) begin
         state_d = IDLE;
         cd_d    = cd_q;
         idx_d   = '0;
         mode_d  = mode_q;
         err_d   = 1'b0;
      end
   end

   assign bus.o_key_ready = (state_q == IDLE);
   assign bus.o_key_err   = err_q;
   assign bus.o_sk        = sk;
   assign bus.o_sk_idx    = idx_q;
   assign bus.o_sk_valid  = (state_q == RUN);
   assign bus.o_sk_last   = (state_q == RUN) && last;
   assign bus.o_done      = (state_q == DONE);
endmodule
